comparator_sort_ctrl: RTL and testbench

Sequential bubble-sort engine that sorts N unsigned 4-bit elements using one shared comparator_4bit instance. It performs one compare, with an optional swap, per clock. It sits between a producer that loads a packed vector and a consumer that reads the sorted vector after a done pulse.

---
 rtl/comparator_pkg.sv | 13 +
 rtl/comparator_4bit.sv | 14 +
 rtl/comparator_sort_ctrl.sv | 125 ++++++++++++
 tb/tb_comparator_sort_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared constants and FSM state encoding for the bubble-sort controller.
package comparator_pkg;

  localparam int ELEM_W     = 4;
  localparam int SWAP_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : comparator_pkg

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator: exactly one of g/e/l is high.
module comparator_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       g_o,
  output logic       e_o,
  output logic       l_o
);

  assign g_o = (a_i >  b_i);
  assign e_o = (a_i == b_i);
  assign l_o = (a_i <  b_i);

endmodule : comparator_4bit

// File: rtl/comparator_sort_ctrl.sv
// Sequential bubble sort of N 4-bit elements, one compare/swap per clock through
// a single shared comparator. Define SORT_DESCEND_EN for descending order.
module comparator_sort_ctrl
  import comparator_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ELEM_W*N-1:0]   data_in,
  output logic                  busy,
  output logic                  done,
  output logic [ELEM_W*N-1:0]   data_out,
  output logic [SWAP_CNT_W-1:0] swap_count
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  state_e                  state_q;
  logic [ELEM_W-1:0]       elem_q [N];
  logic [CW-1:0]           idx_q;
  logic [CW-1:0]           pass_q;
  logic                    pass_swapped_q;
  logic                    busy_q;
  logic                    done_q;
  logic [SWAP_CNT_W-1:0]   swap_cnt_q;

  logic [CW-1:0]     idx_d;
  logic [CW-1:0]     last_idx;
  logic [ELEM_W-1:0] cmp_a;
  logic [ELEM_W-1:0] cmp_b;
  logic              cmp_g;
  logic              cmp_e;
  logic              cmp_l;
  logic              swap_req;
  logic              cmp_unused;
  logic              end_of_pass;

  assign idx_d       = idx_q + CW'(1);
  assign last_idx    = CW'(N - 2) - pass_q;
  assign end_of_pass = (idx_q == last_idx);
  assign cmp_a       = elem_q[idx_q];
  assign cmp_b       = elem_q[idx_d];

  comparator_4bit u_cmp (
    .a_i (cmp_a),
    .b_i (cmp_b),
    .g_o (cmp_g),
    .e_o (cmp_e),
    .l_o (cmp_l)
  );

  // Equal elements never satisfy either condition, so both orders stay stable.
`ifdef SORT_DESCEND_EN
  assign swap_req   = cmp_l;
  assign cmp_unused = cmp_e ^ cmp_g;
`else
  assign swap_req   = cmp_g;
  assign cmp_unused = cmp_e ^ cmp_l;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      pass_q         <= '0;
      pass_swapped_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      swap_cnt_q     <= '0;
      // NOTE: the element array is reset on purpose; it drives data_out directly.
      for (int i = 0; i < N; i++) elem_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int i = 0; i < N; i++) elem_q[i] <= data_in[i*ELEM_W +: ELEM_W];
            swap_cnt_q     <= '0;
            pass_q         <= '0;
            idx_q          <= '0;
            pass_swapped_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= CMP;
          end
        end
        CMP: begin
          if (swap_req) begin
            elem_q[idx_q]  <= cmp_b;
            elem_q[idx_d]  <= cmp_a;
            pass_swapped_q <= 1'b1;
            if (swap_cnt_q != '1) swap_cnt_q <= swap_cnt_q + 1'b1;
          end
          if (!end_of_pass) begin
            idx_q <= idx_d;
          end else if (pass_q == CW'(N - 2) || !(pass_swapped_q || swap_req)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            // NOTE: non-blocking, so this clear overrides the set above for the new pass.
            pass_q         <= pass_q + CW'(1);
            idx_q          <= '0;
            pass_swapped_q <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign data_out[g*ELEM_W +: ELEM_W] = elem_q[g];
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_cnt_q;

endmodule : comparator_sort_ctrl

// File: tb/tb_comparator_sort_ctrl.sv
// Directed bench for comparator_sort_ctrl (N=4): ordering, latency, swap count,
// start-while-busy and mid-sort reset.
module tb_comparator_sort_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic [5:0]  swap_count;

  int checks   = 0;
  int failures = 0;

  comparator_sort_ctrl #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns in cycle k+1 (the cycle after the accepting edge k), start low again.
  task automatic do_start(input logic [15:0] d);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Samples the current cycle as number n0, then each later cycle; done_cyc stays -1 on timeout.
  task automatic wait_done(input int n0, output int done_cyc, output int busy_cyc);
    done_cyc = -1;
    busy_cyc = 0;
    for (int n = n0; n < n0 + 100; n++) begin
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_out); end
    checks++; if (swap_count !== 6'd0) begin failures++; $display("FAIL reset_swaps got=%0d exp=0", swap_count); end
    rst = 1'b0;
  endtask

  task automatic test_sort(input string name, input logic [15:0] d, input logic [15:0] exp_out,
                           input int exp_swaps, input int exp_done_cyc);
    int dc, bc;
    do_start(d);
    wait_done(1, dc, bc);
    checks++; if (dc != exp_done_cyc) begin failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, dc, exp_done_cyc); end
    checks++; if (bc != exp_done_cyc - 1) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, exp_done_cyc - 1); end
    checks++; if (data_out !== exp_out) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, data_out, exp_out); end
    checks++; if (swap_count !== 6'(exp_swaps)) begin failures++; $display("FAIL %s_swaps got=%0d exp=%0d", name, swap_count, exp_swaps); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s_pulse got done=%b busy=%b exp done=0 busy=0", name, done, busy); end
    checks++; if (data_out !== exp_out) begin failures++; $display("FAIL %s_hold got=%h exp=%h", name, data_out, exp_out); end
  endtask

  task automatic test_start_while_busy();
    int dc, bc;
    do_start(16'h2415);
    @(negedge clk);                  // cycle k+2
    start = 1'b1; data_in = 16'h0123;
    @(negedge clk);                  // cycle k+3
    start = 1'b0;
    wait_done(3, dc, bc);
    checks++; if (dc != 7) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=7", dc); end
    checks++; if (data_out !== 16'h5421) begin failures++; $display("FAIL busy_start_data got=%h exp=5421", data_out); end
    checks++; if (swap_count !== 6'd4) begin failures++; $display("FAIL busy_start_swaps got=%0d exp=4", swap_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sort();
    int done_seen = 0;
    do_start(16'h0123);
    @(negedge clk);                  // cycle k+2
    @(negedge clk);                  // cycle k+3
    rst = 1'b1;
    @(negedge clk);                  // cycle k+4
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL abort_data got=%h exp=0000", data_out); end
    checks++; if (swap_count !== 6'd0) begin failures++; $display("FAIL abort_swaps got=%0d exp=0", swap_count); end
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d active cycles exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
`ifdef SORT_DESCEND_EN
    // 5,1,4,2: pass 0 swaps twice, pass 1 is clean -> 5 compares, 2 swaps.
    test_sort("descend", 16'h2415, 16'h1245, 2, 6);
    test_sort("descend_equal", 16'h7777, 16'h7777, 0, 4);
`else
    test_sort("unsorted", 16'h2415, 16'h5421, 4, 7);
    test_sort("sorted", 16'h3210, 16'h3210, 0, 4);
    test_sort("reverse", 16'h0123, 16'h3210, 6, 7);
    test_sort("equal", 16'h7777, 16'h7777, 0, 4);
    test_start_while_busy();
`endif
    test_reset_mid_sort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_comparator_sort_ctrl
